line_fill_mem: RTL and testbench

//   Backing-memory stage directly downstream of cache_controller. Services line fills
//   (read-miss/allocate) and dirty-line writebacks (evict), one full line per request.

---
 rtl/line_fill_mem_if.sv | 34 +++
 rtl/line_fill_mem.sv | 158 +++++++++++++++
 tb/tb_line_fill_mem.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/line_fill_mem_if.sv
// Request/response bundle between the cache controller (master) and line_fill_mem (slave).
// Line data is packed word0-first: word k occupies bits [32*k+31:32*k].
interface line_fill_mem_if #(
    parameter int ADDR_W     = 32,
    parameter int LINE_WORDS = 4
);
    logic                      req_valid;
    logic                      req_ready;
    logic                      req_rw;
    logic [ADDR_W-1:0]         req_addr;
    logic [32*LINE_WORDS-1:0]  req_wline;
    logic                      resp_valid;
    logic [32*LINE_WORDS-1:0]  resp_rline;

    modport master (
        output req_valid,
        output req_rw,
        output req_addr,
        output req_wline,
        input  req_ready,
        input  resp_valid,
        input  resp_rline
    );

    modport slave (
        input  req_valid,
        input  req_rw,
        input  req_addr,
        input  req_wline,
        output req_ready,
        output resp_valid,
        output resp_rline
    );
endinterface

// File: rtl/line_fill_mem.sv
// Backing memory behind the cache: serves whole-line fills and writebacks with a fixed
// access latency; words never written read back as their own byte address.
module line_fill_mem #(
    parameter int ADDR_W     = 32,
    parameter int LINE_WORDS = 4,
    parameter int MEM_WORDS  = 4096,
    parameter int LATENCY    = 4
) (
    input  logic           clk,
    input  logic           rst,
    line_fill_mem_if.slave bus,
    output logic           busy,
    output logic [15:0]    fill_cnt,
    output logic [15:0]    wb_cnt
);
    // state   | meaning
    // S_IDLE  | ready for a request
    // S_WAIT  | access latency countdown
    // S_BURST | one word per cycle, plus one cycle to land the last read word
    // S_RESP  | one-cycle completion pulse, counter update
    localparam int LW = $clog2(LINE_WORDS);
    localparam int MW = $clog2(MEM_WORDS);
    localparam int LB = LW + 2;
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam int DW = 32 * LINE_WORDS;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_BURST, S_RESP} state_t;

    state_t               r_state;
    logic                 r_rw;
    logic [ADDR_W-1:0]    r_base;
    logic [DW-1:0]        r_wline;
    logic [LW:0]          r_beat;
    logic [CW-1:0]        r_wait_cnt;
    logic                 r_rd_pend;
    logic [LW-1:0]        r_rd_k;
    logic                 r_flag_q;
    logic [31:0]          r_pat_q;
    logic [31:0]          r_mem_q;
    logic [MEM_WORDS-1:0] r_flag;
    logic [31:0]          r_mem [MEM_WORDS];
    logic [DW-1:0]        r_rline;
    logic                 r_resp_valid;
    logic                 r_ready;
    logic                 r_busy;
    logic [15:0]          r_fill_cnt;
    logic [15:0]          r_wb_cnt;

    logic                 w_accept;
    logic                 w_issue;
    logic                 w_wr_en;
    logic [LW-1:0]        w_k;
    logic [MW-1:0]        w_idx;
    logic [ADDR_W-1:0]    w_byte_addr;
    logic [ADDR_W-1:0]    w_line_mask;
    logic [31:0]          w_wr_word;

    assign w_accept    = bus.req_valid && r_ready;
    assign w_k         = r_beat[LW-1:0];
    assign w_issue     = (r_state == S_BURST) && !r_beat[LW];
    assign w_wr_en     = w_issue && r_rw;
    // Upper address bits are dropped here, which is what makes the array wrap.
    assign w_idx       = {r_base[MW+1:LB], w_k};
    assign w_byte_addr = r_base | (ADDR_W'(w_k) << 2);
    assign w_line_mask = ~{{(ADDR_W-LB){1'b0}}, {LB{1'b1}}};
    assign w_wr_word   = r_wline[{w_k, 5'b00000} +: 32];

    assign bus.req_ready  = r_ready;
    assign bus.resp_valid = r_resp_valid;
    assign bus.resp_rline = r_rline;
    assign busy           = r_busy;
    assign fill_cnt       = r_fill_cnt;
    assign wb_cnt         = r_wb_cnt;

    // Storage array has no reset; validity is tracked by r_flag instead.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[w_idx] <= w_wr_word;
        end
        r_mem_q <= r_mem[w_idx];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_rw         <= 1'b0;
            r_base       <= '0;
            r_wline      <= '0;
            r_beat       <= '0;
            r_wait_cnt   <= '0;
            r_rd_pend    <= 1'b0;
            r_rd_k       <= '0;
            r_flag_q     <= 1'b0;
            r_pat_q      <= '0;
            r_flag       <= '0;
            r_rline      <= '0;
            r_resp_valid <= 1'b0;
            r_ready      <= 1'b1;
            r_busy       <= 1'b0;
            r_fill_cnt   <= '0;
            r_wb_cnt     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_rw       <= bus.req_rw;
                        r_base     <= bus.req_addr & w_line_mask;
                        r_wline    <= bus.req_wline;
                        r_beat     <= '0;
                        r_rd_pend  <= 1'b0;
                        r_wait_cnt <= CW'((LATENCY > 0) ? LATENCY - 1 : 0);
                        r_ready    <= 1'b0;
                        r_busy     <= 1'b1;
                        r_state    <= (LATENCY == 0) ? S_BURST : S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (r_wait_cnt == '0) begin
                        r_state <= S_BURST;
                    end else begin
                        r_wait_cnt <= r_wait_cnt - 1'b1;
                    end
                end
                S_BURST: begin
                    // Reads are one cycle deep: beat k is captured while beat k+1 issues.
                    r_rd_pend <= w_issue && !r_rw;
                    r_rd_k    <= w_k;
                    if (r_rd_pend) begin
                        r_rline[{r_rd_k, 5'b00000} +: 32] <= r_flag_q ? r_mem_q : r_pat_q;
                    end
                    if (w_issue) begin
                        r_beat   <= r_beat + (LW+1)'(1);
                        r_flag_q <= r_flag[w_idx];
                        r_pat_q  <= 32'(w_byte_addr);
                        if (r_rw) begin
                            r_flag[w_idx] <= 1'b1;
                        end
                    end else begin
                        r_resp_valid <= 1'b1;
                        r_state      <= S_RESP;
                    end
                end
                S_RESP: begin
                    r_resp_valid <= 1'b0;
                    r_ready      <= 1'b1;
                    r_busy       <= 1'b0;
                    r_state      <= S_IDLE;
                    if (r_rw) begin
                        if (r_wb_cnt != 16'hFFFF) r_wb_cnt <= r_wb_cnt + 16'd1;
                    end else begin
                        if (r_fill_cnt != 16'hFFFF) r_fill_cnt <= r_fill_cnt + 16'd1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_line_fill_mem.sv
// Directed bench for line_fill_mem: a LATENCY=4 instance plus a LATENCY=0 instance.
module tb_line_fill_mem;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        busy, busy0;
    logic [15:0] fill_cnt, wb_cnt, fill_cnt0, wb_cnt0;
    int          checks = 0;
    int          errors = 0;

    localparam logic [127:0] PAT_4000 = {32'h0000400C, 32'h00004008, 32'h00004004, 32'h00004000};
    localparam logic [127:0] PAT_8000 = {32'h8000000C, 32'h80000008, 32'h80000004, 32'h80000000};
    localparam logic [127:0] PAT_0010 = {32'h0000001C, 32'h00000018, 32'h00000014, 32'h00000010};
    localparam logic [127:0] PAT_0100 = {32'h0000010C, 32'h00000108, 32'h00000104, 32'h00000100};
    localparam logic [127:0] WL1 = {32'h44444444, 32'h33333333, 32'h22222222, 32'hAABBCCDD};
    localparam logic [127:0] WL2 = {32'h0D0D0D0D, 32'h0C0C0C0C, 32'h0B0B0B0B, 32'h0A0A0A0A};
    localparam logic [127:0] WL3 = {32'h00000004, 32'h00000003, 32'h00000002, 32'h00000001};
    localparam logic [127:0] WL4 = {32'h99999999, 32'h88888888, 32'h77777777, 32'h66666666};

    line_fill_mem_if #(.ADDR_W(32), .LINE_WORDS(4)) bus ();
    line_fill_mem_if #(.ADDR_W(32), .LINE_WORDS(4)) bus0 ();

    line_fill_mem #(.ADDR_W(32), .LINE_WORDS(4), .MEM_WORDS(4096), .LATENCY(4)) u_dut (
        .clk(clk), .rst(rst), .bus(bus), .busy(busy), .fill_cnt(fill_cnt), .wb_cnt(wb_cnt)
    );

    line_fill_mem #(.ADDR_W(32), .LINE_WORDS(4), .MEM_WORDS(4096), .LATENCY(0)) u_dut0 (
        .clk(clk), .rst(rst), .bus(bus0), .busy(busy0), .fill_cnt(fill_cnt0), .wb_cnt(wb_cnt0)
    );

    always #5 clk = ~clk;

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    // One request on the selected DUT; returns cycles from accept to resp_valid.
    task automatic do_req(input bit d0, input logic rw, input logic [31:0] addr,
                          input logic [127:0] wl, output int lat, output logic [127:0] rl,
                          output logic busy_e, output logic resp_next);
        int n = 0;
        @(negedge clk);
        while (!(d0 ? bus0.req_ready : bus.req_ready) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (d0) begin
            bus0.req_rw = rw; bus0.req_addr = addr; bus0.req_wline = wl; bus0.req_valid = 1'b1;
        end else begin
            bus.req_rw = rw; bus.req_addr = addr; bus.req_wline = wl; bus.req_valid = 1'b1;
        end
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;  bus.req_addr = 32'hDEADBEEF;  bus.req_wline = '1;  bus.req_rw = ~rw;
        bus0.req_valid = 1'b0; bus0.req_addr = 32'hDEADBEEF; bus0.req_wline = '1; bus0.req_rw = ~rw;
        busy_e = d0 ? busy0 : busy;
        lat = 0;
        rl = '0;
        while (lat < 60) begin
            @(posedge clk);
            #1;
            lat++;
            if (d0 ? bus0.resp_valid : bus.resp_valid) begin
                rl = d0 ? bus0.resp_rline : bus.resp_rline;
                break;
            end
        end
        @(posedge clk);
        #1;
        resp_next = d0 ? bus0.resp_valid : bus.resp_valid;
    endtask

    task automatic test_reset();
        apply_reset();
        #1;
        checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", bus.req_ready); end
        checks++; if (bus.resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid: got %b expected 0", bus.resp_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (bus.resp_rline !== 128'd0) begin errors++; $display("FAIL reset_rline: got %h expected 0", bus.resp_rline); end
        checks++; if (fill_cnt !== 16'd0) begin errors++; $display("FAIL reset_fill_cnt: got %0d expected 0", fill_cnt); end
        checks++; if (wb_cnt !== 16'd0) begin errors++; $display("FAIL reset_wb_cnt: got %0d expected 0", wb_cnt); end
    endtask

    task automatic test_fill();
        int lat; logic [127:0] rl; logic be, rn;
        do_req(1'b0, 1'b0, 32'h00004000, '0, lat, rl, be, rn);
        checks++; if (lat !== 9) begin errors++; $display("FAIL fill_latency: got %0d expected 9", lat); end
        checks++; if (rl !== PAT_4000) begin errors++; $display("FAIL fill_pattern_4000: got %h expected %h", rl, PAT_4000); end
        checks++; if (be !== 1'b1) begin errors++; $display("FAIL fill_busy: got %b expected 1", be); end
        checks++; if (rn !== 1'b0) begin errors++; $display("FAIL fill_resp_one_cycle: got %b expected 0", rn); end
        checks++; if (fill_cnt !== 16'd1) begin errors++; $display("FAIL fill_cnt_1: got %0d expected 1", fill_cnt); end
        checks++; if (wb_cnt !== 16'd0) begin errors++; $display("FAIL fill_wb_cnt: got %0d expected 0", wb_cnt); end
        do_req(1'b0, 1'b0, 32'h8000000C, '0, lat, rl, be, rn);
        checks++; if (rl !== PAT_8000) begin errors++; $display("FAIL fill_pattern_8000: got %h expected %h", rl, PAT_8000); end
        checks++; if (fill_cnt !== 16'd2) begin errors++; $display("FAIL fill_cnt_2: got %0d expected 2", fill_cnt); end
    endtask

    task automatic test_wb_fill();
        int lat; logic [127:0] rl; logic be, rn;
        apply_reset();
        do_req(1'b0, 1'b1, 32'h80000000, WL1, lat, rl, be, rn);
        checks++; if (lat !== 9) begin errors++; $display("FAIL wb_latency: got %0d expected 9", lat); end
        checks++; if (rl !== 128'd0) begin errors++; $display("FAIL wb_rline_unchanged: got %h expected 0", rl); end
        checks++; if (wb_cnt !== 16'd1 || fill_cnt !== 16'd0) begin errors++; $display("FAIL wb_counts: got wb=%0d fill=%0d expected wb=1 fill=0", wb_cnt, fill_cnt); end
        do_req(1'b0, 1'b0, 32'h80000008, '0, lat, rl, be, rn);
        checks++; if (rl !== WL1) begin errors++; $display("FAIL wb_then_fill: got %h expected %h", rl, WL1); end
        checks++; if (wb_cnt !== 16'd1 || fill_cnt !== 16'd1) begin errors++; $display("FAIL wb_fill_counts: got wb=%0d fill=%0d expected wb=1 fill=1", wb_cnt, fill_cnt); end
    endtask

    task automatic test_wrap();
        int lat; logic [127:0] rl; logic be, rn;
        do_req(1'b0, 1'b1, 32'h00000000, WL2, lat, rl, be, rn);
        checks++; if (rl !== WL1) begin errors++; $display("FAIL wrap_wb_keeps_rline: got %h expected %h", rl, WL1); end
        do_req(1'b0, 1'b0, 32'h00004000, '0, lat, rl, be, rn);
        checks++; if (rl !== WL2) begin errors++; $display("FAIL wrap_fill: got %h expected %h", rl, WL2); end
        do_req(1'b0, 1'b0, 32'h00000010, '0, lat, rl, be, rn);
        checks++; if (rl !== PAT_0010) begin errors++; $display("FAIL wrap_next_line: got %h expected %h", rl, PAT_0010); end
    endtask

    task automatic test_back_to_back();
        int n = 0; logic [15:0] f0; logic exp_r, exp_v;
        @(negedge clk);
        while (!bus.req_ready && n < 100) begin @(negedge clk); n++; end
        f0 = fill_cnt;
        bus.req_rw = 1'b0; bus.req_addr = 32'h00000040; bus.req_valid = 1'b1;
        for (int j = 0; j < 34; j++) begin
            exp_r = (j % 11 == 0);
            exp_v = (j % 11 == 10);
            checks++; if (bus.req_ready !== exp_r) begin errors++; $display("FAIL b2b_ready cycle %0d: got %b expected %b", j, bus.req_ready, exp_r); end
            checks++; if (bus.resp_valid !== exp_v) begin errors++; $display("FAIL b2b_resp_valid cycle %0d: got %b expected %b", j, bus.resp_valid, exp_v); end
            if (j == 33) bus.req_valid = 1'b0;
            @(negedge clk);
        end
        checks++; if (fill_cnt !== 16'(f0 + 16'd3)) begin errors++; $display("FAIL b2b_fill_cnt: got %0d expected %0d", fill_cnt, f0 + 16'd3); end
    endtask

    task automatic test_reset_mid_burst();
        int n = 0; int lat; logic [127:0] rl; logic be, rn;
        @(negedge clk);
        while (!bus.req_ready && n < 100) begin @(negedge clk); n++; end
        bus.req_rw = 1'b1; bus.req_addr = 32'h00000100; bus.req_wline = WL4; bus.req_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        checks++; if (bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL midrst_ctrl: got ready=%b resp=%b busy=%b expected 1 0 0", bus.req_ready, bus.resp_valid, busy); end
        checks++; if (bus.resp_rline !== 128'd0) begin errors++; $display("FAIL midrst_rline: got %h expected 0", bus.resp_rline); end
        checks++; if (fill_cnt !== 16'd0 || wb_cnt !== 16'd0) begin errors++; $display("FAIL midrst_counts: got fill=%0d wb=%0d expected 0 0", fill_cnt, wb_cnt); end
        @(negedge clk);
        rst = 1'b1;
        do_req(1'b0, 1'b0, 32'h00000100, '0, lat, rl, be, rn);
        checks++; if (rl !== PAT_0100) begin errors++; $display("FAIL midrst_fill: got %h expected %h", rl, PAT_0100); end
        checks++; if (wb_cnt !== 16'd0 || fill_cnt !== 16'd1) begin errors++; $display("FAIL midrst_after_counts: got wb=%0d fill=%0d expected 0 1", wb_cnt, fill_cnt); end
        do_req(1'b0, 1'b0, 32'h80000000, '0, lat, rl, be, rn);
        checks++; if (rl !== PAT_8000) begin errors++; $display("FAIL midrst_flags_cleared: got %h expected %h", rl, PAT_8000); end
    endtask

    task automatic test_latency0();
        int lat; logic [127:0] rl; logic be, rn;
        do_req(1'b1, 1'b0, 32'h00004000, '0, lat, rl, be, rn);
        checks++; if (lat !== 5) begin errors++; $display("FAIL lat0_latency: got %0d expected 5", lat); end
        checks++; if (rl !== PAT_4000) begin errors++; $display("FAIL lat0_pattern: got %h expected %h", rl, PAT_4000); end
        checks++; if (rn !== 1'b0) begin errors++; $display("FAIL lat0_resp_one_cycle: got %b expected 0", rn); end
        do_req(1'b1, 1'b1, 32'h00000020, WL3, lat, rl, be, rn);
        checks++; if (lat !== 5) begin errors++; $display("FAIL lat0_wb_latency: got %0d expected 5", lat); end
        do_req(1'b1, 1'b0, 32'h00000028, '0, lat, rl, be, rn);
        checks++; if (rl !== WL3) begin errors++; $display("FAIL lat0_wb_fill: got %h expected %h", rl, WL3); end
        checks++; if (fill_cnt0 !== 16'd2 || wb_cnt0 !== 16'd1) begin errors++; $display("FAIL lat0_counts: got fill=%0d wb=%0d expected 2 1", fill_cnt0, wb_cnt0); end
    endtask

    initial begin
        bus.req_valid = 1'b0;  bus.req_rw = 1'b0;  bus.req_addr = '0;  bus.req_wline = '0;
        bus0.req_valid = 1'b0; bus0.req_rw = 1'b0; bus0.req_addr = '0; bus0.req_wline = '0;
        test_reset();
        test_fill();
        test_wb_fill();
        test_wrap();
        test_back_to_back();
        test_reset_mid_burst();
        test_latency0();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached with %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog");
    end
endmodule
